dsp_mac_pipe: RTL and testbench
===============================

Name: dsp_mac_pipe

Overview:
- Parametrised, runtime-configurable successor of the fixed 4-stage DSP slice.
- Datapath: pre-adder (D ± B), multiplier (A × pre), post-adder (± C or accumulate onto P).
- Operands are signed two's complement, with configurable widths.
- Adds a valid pipeline, clock enable, per-sample opmode and an accumulate mode; sits in filter/MAC datapaths.

Parameters:
- A_W, 18, width of A (signed).
- B_W, 18, width of B and D (signed).
- C_W, 48, width of C (signed); C_W <= P_W.
- P_W, 48, width of P; must be >= A_W + B_W + 1 (elaboration-time check, $error if violated).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every pipeline register, including valids.
- in_valid  in  1  operands/opmode valid this cycle.
- a  in  A_W  multiplier operand.
- b  in  B_W  pre-adder operand 2.
- d  in  B_W  pre-adder operand 1.
- c  in  C_W  post-adder operand.
- opmode  in  3  [0] pre: 0 add, 1 sub (d-b); [1] post: 0 add, 1 sub; [2] Z-select: 0 C, 1 accumulate onto P.
- out_valid  out  1  P holds a new result.
- p  out  P_W  result.

Behaviour:
- Reset (async, rst=1): all pipeline registers, p and out_valid go to 0 immediately, including mid-operation; in-flight samples are discarded. First capture is on the first rising edge with rst=0 and ce=1.
- Pipeline, all stages advancing only when ce=1:
  - S1: register a, b, d, c, opmode, in_valid.
  - S2: pre = d ± b, width B_W+1, no overflow possible; a delayed one more stage; c, opmode, valid carried forward.
  - S3: m = a_s2 × pre, width A_W+B_W+1, signed.
  - S4: z = (opmode[2] ? p : sign-extended c); p <= z ± sign-extended m; out_valid <= valid_s3.
- Latency: exactly 4 enabled cycles from in_valid to out_valid. Throughput is one sample per enabled cycle.
- Bubbles: when valid_s3=0 at S4, p holds its value and out_valid=0. Bubbles never disturb the accumulator.
- Accumulate: feedback uses the current p register, so back-to-back accumulating samples chain with no gap. First sample of an accumulation uses opmode[2]=0 with c=0 (or c=bias).
- Post-adder wraps modulo 2^P_W in base build.
- ce=0 while in_valid=1: the input sample is not captured; the upstream producer must hold it.
- ce=0 freezes p and out_valid at their current values.
- Opmode bits travel with their sample; changing opmode every cycle is legal.

Optional Feature:
- Macro DSP_MAC_SAT_EN.
- Defined:
  - Post-adder is computed at P_W+1 bits and saturated to [-2^(P_W-1), 2^(P_W-1)-1].
  - Extra output port ovf (1 bit): registered with p, 1 for the cycle the result saturated, reset 0, frozen by ce.
- Undefined: wrap-around, and no ovf port.

Decomposition:
- Package dsp_pkg:
  - opmode bit-index constants OP_PRE_SUB=0, OP_POST_SUB=1, OP_ACC=2.
  - opmode_t packed struct {acc, post_sub, pre_sub}.
  - Saturation helper function.
- One natural sub-module: dsp_preadd (registered pre-adder stage, width-parametrised), reusable by future symmetric-FIR blocks.
- Multiplier and post-adder stay inline.

Test Plan:
- Basic: a=3, d=10, b=4, c=100, opmode=000 -> p=142, out_valid high exactly 4 cycles after in_valid.
- Subtract modes: a=-2, d=5, b=7, c=50, opmode=011 -> pre=-2, m=4, p=4-50=-46.
- Accumulate: 4 back-to-back samples a=1, d=i, b=0 (i=1..4), first opmode=000 with c=0, rest opmode=100 -> p sequence 1, 3, 6, 10. Insert a bubble mid-stream -> p holds 3 during the bubble, final result still 10.
- Clock enable: drop ce for 3 cycles with 2 samples in flight -> p, out_valid and stage contents frozen; outputs resume with total latency 4+3 cycles.
- Async reset mid-stream: assert rst between edges with 3 samples in flight -> p=0 and out_valid=0 immediately; no stale results after release.
- Overflow, full signed range: accumulate 0x7FFF_FFFF_FFFF + 1 -> base build wraps to 0x8000_0000_0000; with DSP_MAC_SAT_EN, p=0x7FFF_FFFF_FFFF and ovf=1 for one cycle.

Source files
------------

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - opmode encoding and saturation helper shared by the dsp_mac_pipe slice
package dsp_pkg;

  localparam int OP_PRE_SUB  = 0;
  localparam int OP_POST_SUB = 1;
  localparam int OP_ACC      = 2;

  typedef struct packed {
    logic acc;
    logic post_sub;
    logic pre_sub;
  } opmode_t;

  // A sum carried one bit wider than its operands overflowed when its top two bits disagree.
  function automatic logic sum_overflowed(input logic guard_bit, input logic sign_bit);
    return guard_bit ^ sign_bit;
  endfunction

endpackage

// File: rtl/dsp_preadd.sv
// rtl/dsp_preadd.sv - registered signed pre-adder, pre_o <= d_i +/- b_i at W+1 bits (cannot overflow)
module dsp_preadd #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_i,
  input  logic         sub_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   pre_o
);

  logic [W:0] d_ext, b_ext, pre_d, pre_q;

  always_comb begin
    d_ext = {d_i[W-1], d_i};
    b_ext = {b_i[W-1], b_i};
    pre_d = sub_i ? (d_ext - b_ext) : (d_ext + b_ext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (ce_i) begin
      pre_q <= pre_d;
    end
  end

  assign pre_o = pre_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - 4-stage pre-add / multiply / post-add MAC with valid pipeline, ce and accumulate
// Define DSP_MAC_SAT_EN for a saturating post-adder and the ovf output.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int C_W = 48,
  parameter int P_W = 48
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [B_W-1:0] d,
  input  logic [C_W-1:0] c,
  input  logic [2:0]     opmode,
  output logic           out_valid,
  output logic [P_W-1:0] p
`ifdef DSP_MAC_SAT_EN
  ,
  output logic           ovf
`endif
);

  localparam int M_W = A_W + B_W + 1;

  if (P_W < M_W) begin : g_bad_p_w
    $error("dsp_mac_pipe: P_W must be at least A_W + B_W + 1");
  end
  if (C_W > P_W) begin : g_bad_c_w
    $error("dsp_mac_pipe: C_W must not exceed P_W");
  end

  opmode_t              op_in, op_s1_q;
  logic [A_W-1:0]       a_s1_q, a_s2_q;
  logic [B_W-1:0]       b_s1_q, d_s1_q;
  logic [C_W-1:0]       c_s1_q, c_s2_q, c_s3_q;
  logic                 vld_s1_q, vld_s2_q, vld_s3_q;
  logic                 post_sub_s2_q, post_sub_s3_q;
  logic                 acc_s2_q, acc_s3_q;
  logic [B_W:0]         pre_s2;
  logic signed [M_W-1:0] m_d, m_s3_q;
  logic [P_W-1:0]       m_ext, c_ext, z, p_d, p_q;
  logic                 out_valid_q;

  always_comb begin
    op_in          = '0;
    op_in.pre_sub  = opmode[OP_PRE_SUB];
    op_in.post_sub = opmode[OP_POST_SUB];
    op_in.acc      = opmode[OP_ACC];
  end

  // S1: operand capture; data registers load every enabled cycle, in_valid marks real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1_q   <= '0;
      b_s1_q   <= '0;
      d_s1_q   <= '0;
      c_s1_q   <= '0;
      op_s1_q  <= '0;
      vld_s1_q <= 1'b0;
    end else if (ce) begin
      a_s1_q   <= a;
      b_s1_q   <= b;
      d_s1_q   <= d;
      c_s1_q   <= c;
      op_s1_q  <= op_in;
      vld_s1_q <= in_valid;
    end
  end

  dsp_preadd #(.W(B_W)) u_preadd (
    .clk   (clk),
    .rst   (rst),
    .ce_i  (ce),
    .sub_i (op_s1_q.pre_sub),
    .d_i   (d_s1_q),
    .b_i   (b_s1_q),
    .pre_o (pre_s2)
  );

  // S2 side-band registers run alongside the pre-adder; S3 holds the product.
  always_comb begin
    m_d = M_W'($signed(a_s2_q)) * M_W'($signed(pre_s2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s2_q        <= '0;
      c_s2_q        <= '0;
      post_sub_s2_q <= 1'b0;
      acc_s2_q      <= 1'b0;
      vld_s2_q      <= 1'b0;
      m_s3_q        <= '0;
      c_s3_q        <= '0;
      post_sub_s3_q <= 1'b0;
      acc_s3_q      <= 1'b0;
      vld_s3_q      <= 1'b0;
    end else if (ce) begin
      a_s2_q        <= a_s1_q;
      c_s2_q        <= c_s1_q;
      post_sub_s2_q <= op_s1_q.post_sub;
      acc_s2_q      <= op_s1_q.acc;
      vld_s2_q      <= vld_s1_q;
      m_s3_q        <= m_d;
      c_s3_q        <= c_s2_q;
      post_sub_s3_q <= post_sub_s2_q;
      acc_s3_q      <= acc_s2_q;
      vld_s3_q      <= vld_s2_q;
    end
  end

  // S4: feedback reads p_q directly so consecutive accumulating samples chain without a gap.
  // Subtract mode yields product minus Z.
  always_comb begin
    m_ext = P_W'(m_s3_q);
    c_ext = P_W'($signed(c_s3_q));
    z     = acc_s3_q ? p_q : c_ext;
  end

`ifdef DSP_MAC_SAT_EN
  logic [P_W:0] sum_w;
  logic         sat_hit;
  logic         ovf_q;

  always_comb begin
    sum_w   = post_sub_s3_q ? ({m_ext[P_W-1], m_ext} - {z[P_W-1], z})
                            : ({m_ext[P_W-1], m_ext} + {z[P_W-1], z});
    sat_hit = sum_overflowed(sum_w[P_W], sum_w[P_W-1]);
    if (!sat_hit) begin
      p_d = sum_w[P_W-1:0];
    end else if (sum_w[P_W]) begin
      p_d = {1'b1, {(P_W-1){1'b0}}};
    end else begin
      p_d = {1'b0, {(P_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ce) begin
      ovf_q <= vld_s3_q & sat_hit;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    p_d = post_sub_s3_q ? (m_ext - z) : (m_ext + z);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      out_valid_q <= vld_s3_q;
      if (vld_s3_q) begin
        p_q <= p_d;
      end
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - self-checking bench for dsp_mac_pipe, default parameters
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic [2:0]  opmode;
  logic        out_valid;
  logic [47:0] p;
`ifdef DSP_MAC_SAT_EN
  logic        ovf;
`endif

  int tests = 0;
  int fails = 0;
  logic [47:0] model_p;

  typedef struct {
    int          due;
    logic [47:0] p;
    logic        ovf;
  } exp_t;

  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -64'sh0000_8000_0000_0000;

  dsp_mac_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .d         (d),
    .c         (c),
    .opmode    (opmode),
    .out_valid (out_valid),
    .p         (p)
`ifdef DSP_MAC_SAT_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input int ai, input int bi, input int di,
                        input longint ci, input logic [2:0] op);
    in_valid = v;
    a        = 18'(ai);
    b        = 18'(bi);
    d        = 18'(di);
    c        = 48'(ci);
    opmode   = op;
  endtask

  // Reference: plain integer arithmetic of one sample against the running result.
  function automatic void model_step(input logic [47:0] prev, input logic [17:0] ai,
                                     input logic [17:0] bi, input logic [17:0] di,
                                     input logic [47:0] ci, input logic [2:0] op,
                                     output logic [47:0] res, output logic sat);
    longint la, lb, ld, lc, lp, pre, m, z, r;
    la  = longint'($signed(ai));
    lb  = longint'($signed(bi));
    ld  = longint'($signed(di));
    lc  = longint'($signed(ci));
    lp  = longint'($signed(prev));
    pre = op[0] ? (ld - lb) : (ld + lb);
    m   = la * pre;
    z   = op[2] ? lp : lc;
    r   = op[1] ? (m - z) : (m + z);
    sat = 1'b0;
`ifdef DSP_MAC_SAT_EN
    if (r > PMAX) begin
      r   = PMAX;
      sat = 1'b1;
    end else if (r < PMIN) begin
      r   = PMIN;
      sat = 1'b1;
    end
`endif
    res = r[47:0];
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    ce  = 1'b1;
    set_in(1'b0, 0, 0, 0, 0, 3'b000);
    #2;
    tests++;
    if (out_valid !== 1'b0 || p !== 48'h0) begin
      fails++;
      $display("FAIL reset_async: out_valid=%b p=%h, want 0 and 0", out_valid, p);
    end
    tick;
    tick;
    tests++;
    if (out_valid !== 1'b0 || p !== 48'h0) begin
      fails++;
      $display("FAIL reset_held: out_valid=%b p=%h, want 0 and 0", out_valid, p);
    end
`ifdef DSP_MAC_SAT_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
    end
`endif
    rst     = 1'b0;
    model_p = '0;
  endtask

  task automatic test_basic;
    set_in(1'b1, 3, 4, 10, 100, 3'b000);
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 1) set_in(1'b0, 0, 0, 0, 0, 3'b000);
      tests++;
      if (out_valid !== (k == 4)) begin
        fails++;
        $display("FAIL basic_valid edge %0d: out_valid=%b, want %b", k, out_valid, (k == 4));
      end
      if (k >= 4) begin
        tests++;
        if (p !== 48'd142) begin
          fails++;
          $display("FAIL basic_p edge %0d: p=%0d, want 142", k, $signed(p));
        end
      end
    end
    model_p = 48'd142;
  endtask

  task automatic test_subtract;
    set_in(1'b1, -2, 7, 5, 50, 3'b011);
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 1) set_in(1'b0, 0, 0, 0, 0, 3'b000);
      tests++;
      if (out_valid !== (k == 4)) begin
        fails++;
        $display("FAIL sub_valid edge %0d: out_valid=%b, want %b", k, out_valid, (k == 4));
      end
      if (k >= 4) begin
        tests++;
        if (p !== 48'(-46)) begin
          fails++;
          $display("FAIL sub_p edge %0d: p=%0d, want -46", k, $signed(p));
        end
      end
    end
    model_p = 48'(-46);
  endtask

  task automatic test_accumulate;
    logic   ev[9] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
    longint ep[9] = '{-46, -46, -46, 1, 3, 3, 6, 10, 10};
    set_in(1'b1, 1, 0, 1, 0, 3'b000);
    for (int k = 1; k <= 9; k++) begin
      tick;
      case (k)
        1:       set_in(1'b1, 1, 0, 2, 0, 3'b100);
        2:       set_in(1'b0, 0, 0, 0, 0, 3'b000);
        3:       set_in(1'b1, 1, 0, 3, 0, 3'b100);
        4:       set_in(1'b1, 1, 0, 4, 0, 3'b100);
        default: set_in(1'b0, 0, 0, 0, 0, 3'b000);
      endcase
      tests++;
      if (out_valid !== ev[k-1] || p !== 48'(ep[k-1])) begin
        fails++;
        $display("FAIL acc edge %0d: out_valid=%b p=%0d, want %b %0d",
                 k, out_valid, $signed(p), ev[k-1], ep[k-1]);
      end
    end
    model_p = 48'd10;
  endtask

  task automatic test_ce;
    logic   ev[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    longint ep[10] = '{10, 10, 10, 10, 10, 10, 142, -46, 5, 5};
    set_in(1'b1, 3, 4, 10, 100, 3'b000);
    for (int k = 1; k <= 10; k++) begin
      tick;
      case (k)
        1: set_in(1'b1, -2, 7, 5, 50, 3'b011);
        2: begin
          set_in(1'b1, 1, 0, 5, 0, 3'b000);
          ce = 1'b0;
        end
        5: ce = 1'b1;
        6: set_in(1'b0, 0, 0, 0, 0, 3'b000);
        default: ;
      endcase
      tests++;
      if (out_valid !== ev[k-1] || p !== 48'(ep[k-1])) begin
        fails++;
        $display("FAIL ce edge %0d: out_valid=%b p=%0d, want %b %0d",
                 k, out_valid, $signed(p), ev[k-1], ep[k-1]);
      end
    end
    model_p = 48'd5;
  endtask

  task automatic test_async_reset;
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1, 1, 0, k, 0, 3'b000);
      tick;
    end
    tests++;
    if (out_valid !== 1'b1 || p !== 48'd2) begin
      fails++;
      $display("FAIL arst_pre: out_valid=%b p=%0d, want 1 2", out_valid, $signed(p));
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || p !== 48'h0) begin
      fails++;
      $display("FAIL arst_immediate: out_valid=%b p=%h, want 0 0", out_valid, p);
    end
    set_in(1'b0, 0, 0, 0, 0, 3'b000);
    tick;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick;
      tests++;
      if (out_valid !== 1'b0 || p !== 48'h0) begin
        fails++;
        $display("FAIL arst_stale edge %0d: out_valid=%b p=%h, want 0 0", k, out_valid, p);
      end
    end
    model_p = '0;
  endtask

  task automatic test_overflow;
    logic [47:0] want;
`ifdef DSP_MAC_SAT_EN
    want = 48'h7FFF_FFFF_FFFF;
`else
    want = 48'h8000_0000_0000;
`endif
    set_in(1'b1, 0, 0, 0, 64'h7FFF_FFFF_FFFF, 3'b000);
    for (int k = 1; k <= 6; k++) begin
      tick;
      case (k)
        1:       set_in(1'b1, 1, 0, 1, 0, 3'b100);
        default: set_in(1'b0, 0, 0, 0, 0, 3'b000);
      endcase
      if (k == 4) begin
        tests++;
        if (out_valid !== 1'b1 || p !== 48'h7FFF_FFFF_FFFF) begin
          fails++;
          $display("FAIL ovf_load: out_valid=%b p=%h, want 1 7fffffffffff", out_valid, p);
        end
      end
      if (k == 5) begin
        tests++;
        if (out_valid !== 1'b1 || p !== want) begin
          fails++;
          $display("FAIL ovf_result: out_valid=%b p=%h, want 1 %h", out_valid, p, want);
        end
      end
`ifdef DSP_MAC_SAT_EN
      if (k >= 4) begin
        tests++;
        if (ovf !== (k == 5)) begin
          fails++;
          $display("FAIL ovf_flag edge %0d: ovf=%b, want %b", k, ovf, (k == 5));
        end
      end
`endif
    end
    model_p = want;
  endtask

  task automatic test_random;
    exp_t        q[$];
    int          ecnt;
    logic        pending;
    logic [47:0] exp_p;
    logic        exp_ov, exp_ovf;
    logic [47:0] res;
    logic        sat;
    ecnt    = 0;
    pending = 1'b0;
    exp_p   = model_p;
    exp_ov  = 1'b0;
    exp_ovf = 1'b0;
    set_in(1'b0, 0, 0, 0, 0, 3'b000);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pending) begin
        if (cyc < 250 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          a        = 18'($urandom);
          b        = 18'($urandom);
          d        = 18'($urandom);
          c        = 48'($signed(40'({$urandom, $urandom})));
          opmode   = 3'($urandom);
          pending  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      ce = ($urandom_range(0, 4) != 0);
      tick;
      if (ce) begin
        ecnt++;
        if (in_valid) begin
          model_step(model_p, a, b, d, c, opmode, res, sat);
          model_p = res;
          q.push_back('{ecnt + 3, res, sat});
          pending = 1'b0;
        end
        if (q.size() > 0 && q[0].due == ecnt) begin
          exp_ov  = 1'b1;
          exp_p   = q[0].p;
          exp_ovf = q[0].ovf;
          void'(q.pop_front());
        end else begin
          exp_ov  = 1'b0;
          exp_ovf = 1'b0;
        end
      end
      tests++;
      if (out_valid !== exp_ov || p !== exp_p) begin
        fails++;
        $display("FAIL random cyc %0d: out_valid=%b p=%h, want %b %h", cyc, out_valid, p, exp_ov, exp_p);
      end
`ifdef DSP_MAC_SAT_EN
      tests++;
      if (ovf !== exp_ovf) begin
        fails++;
        $display("FAIL random_ovf cyc %0d: ovf=%b, want %b", cyc, ovf, exp_ovf);
      end
`endif
    end
    tests++;
    if (q.size() !== 0) begin
      fails++;
      $display("FAIL random_drain: %0d results never appeared, want 0", q.size());
    end
    ce = 1'b1;
    set_in(1'b0, 0, 0, 0, 0, 3'b000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subtract();
    test_accumulate();
    test_ce();
    test_async_reset();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
